mult_div_unit: RTL and testbench



---
 rtl/mult_div_unit.sv | 201 ++++++++++++++++++++
 tb/tb_mult_div_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Multicycle 32-bit multiply/divide unit with architectural HI/LO registers.
// Define MULTDIV_UNSIGNED_EN to execute Op 01/11 as MULTU/DIVU; otherwise Op[0] is ignored.
module mult_div_unit (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Start,
   input  logic [1:0]  Op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        HiWrite,
   input  logic        LoWrite,
   input  logic [31:0] WriteData,
   output logic        Busy,
   output logic        Done,
   output logic        DivZero,
   output logic [31:0] Hi,
   output logic [31:0] Lo
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PREP,
      S_CALC,
      S_FIX,
      S_DONE
   } state_t;

   state_t      state_q, state_d;
   logic        is_div_q, is_div_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [31:0] acc_q, acc_d;
   logic [31:0] mq_q, mq_d;
   logic [5:0]  cnt_q, cnt_d;
   logic        neg_q, neg_d;
   logic        rem_neg_q, rem_neg_d;
   logic        div_zero_q, div_zero_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;

   logic        signed_op;
   logic [31:0] a_mag, b_mag;
   logic [32:0] mul_sum;
   logic [32:0] div_shift;
   logic [32:0] div_trial;
   logic        div_fits;
   logic [63:0] prod_raw, prod_fixed;
   logic [31:0] quot_fixed, rem_fixed;
   logic        unused_trial_msb;

`ifdef MULTDIV_UNSIGNED_EN
   logic uns_q, uns_d;

   always_comb begin
      uns_d = uns_q;
      if (state_q == S_IDLE && Start) begin
         uns_d = Op[0];
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         uns_q <= 1'b0;
      end else begin
         uns_q <= uns_d;
      end
   end

   assign signed_op = ~uns_q;
`else
   logic unused_op0;

   assign signed_op  = 1'b1;
   assign unused_op0 = Op[0];
`endif

   assign a_mag = (signed_op && a_q[31]) ? (32'd0 - a_q) : a_q;
   assign b_mag = (signed_op && b_q[31]) ? (32'd0 - b_q) : b_q;

   // One iteration of each algorithm; multiplicand/divisor magnitude sits in a_q/b_q.
   assign mul_sum   = {1'b0, acc_q} + (mq_q[0] ? {1'b0, a_q} : 33'd0);
   assign div_shift = {acc_q, mq_q[31]};
   assign div_trial = div_shift - {1'b0, b_q};
   assign div_fits  = (div_shift >= {1'b0, b_q});
   assign unused_trial_msb = div_trial[32];

   assign prod_raw   = {acc_q, mq_q};
   assign prod_fixed = neg_q ? (64'd0 - prod_raw) : prod_raw;
   assign quot_fixed = neg_q ? (32'd0 - mq_q) : mq_q;
   assign rem_fixed  = rem_neg_q ? (32'd0 - acc_q) : acc_q;

   always_comb begin
      state_d    = state_q;
      is_div_d   = is_div_q;
      a_d        = a_q;
      b_d        = b_q;
      acc_d      = acc_q;
      mq_d       = mq_q;
      cnt_d      = cnt_q;
      neg_d      = neg_q;
      rem_neg_d  = rem_neg_q;
      div_zero_d = div_zero_q;
      hi_d       = hi_q;
      lo_d       = lo_q;

      case (state_q)
         S_IDLE: begin
            if (HiWrite) hi_d = WriteData;
            if (LoWrite) lo_d = WriteData;
            if (Start) begin
               a_d        = A;
               b_d        = B;
               is_div_d   = Op[1];
               div_zero_d = 1'b0;
               state_d    = S_PREP;
            end
         end
         S_PREP: begin
            a_d       = a_mag;
            b_d       = b_mag;
            neg_d     = signed_op & (a_q[31] ^ b_q[31]);
            rem_neg_d = signed_op & a_q[31];
            acc_d     = 32'd0;
            mq_d      = is_div_q ? a_mag : b_mag;
            cnt_d     = 6'd0;
            if (is_div_q && b_q == 32'd0) begin
               div_zero_d = 1'b1;
               state_d    = S_DONE;
            end else begin
               state_d = S_CALC;
            end
         end
         S_CALC: begin
            if (is_div_q) begin
               acc_d = div_fits ? div_trial[31:0] : div_shift[31:0];
               mq_d  = {mq_q[30:0], div_fits};
            end else begin
               acc_d = mul_sum[32:1];
               mq_d  = {mul_sum[0], mq_q[31:1]};
            end
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'd31) begin
               state_d = S_FIX;
            end
         end
         S_FIX: begin
            if (is_div_q) begin
               hi_d = rem_fixed;
               lo_d = quot_fixed;
            end else begin
               hi_d = prod_fixed[63:32];
               lo_d = prod_fixed[31:0];
            end
            state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q    <= S_IDLE;
         is_div_q   <= 1'b0;
         a_q        <= 32'd0;
         b_q        <= 32'd0;
         acc_q      <= 32'd0;
         mq_q       <= 32'd0;
         cnt_q      <= 6'd0;
         neg_q      <= 1'b0;
         rem_neg_q  <= 1'b0;
         div_zero_q <= 1'b0;
         hi_q       <= 32'd0;
         lo_q       <= 32'd0;
      end else begin
         state_q    <= state_d;
         is_div_q   <= is_div_d;
         a_q        <= a_d;
         b_q        <= b_d;
         acc_q      <= acc_d;
         mq_q       <= mq_d;
         cnt_q      <= cnt_d;
         neg_q      <= neg_d;
         rem_neg_q  <= rem_neg_d;
         div_zero_q <= div_zero_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
      end
   end

   assign Busy    = (state_q != S_IDLE);
   assign Done    = (state_q == S_DONE);
   assign DivZero = (state_q == S_DONE) & div_zero_q;
   assign Hi      = hi_q;
   assign Lo      = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: arithmetic reference model plus directed vectors.
// Honours MULTDIV_UNSIGNED_EN the same way as the design.
module tb_mult_div_unit;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        Start = 1'b0;
   logic [1:0]  Op = 2'b00;
   logic [31:0] A = 32'd0;
   logic [31:0] B = 32'd0;
   logic        HiWrite = 1'b0;
   logic        LoWrite = 1'b0;
   logic [31:0] WriteData = 32'd0;
   logic        Busy, Done, DivZero;
   logic [31:0] Hi, Lo;

   int checks = 0;
   int errors = 0;

   mult_div_unit dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
      .HiWrite(HiWrite), .LoWrite(LoWrite), .WriteData(WriteData),
      .Busy(Busy), .Done(Done), .DivZero(DivZero), .Hi(Hi), .Lo(Lo)
   );

   always #5 Clk = ~Clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference result straight from integer arithmetic on the operand values.
   function automatic void modelResult(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                       output logic [31:0] hi, output logic [31:0] lo, output logic dz);
      bit uns;
      longint sa, sb, q, r;
      logic [63:0] p, qv, rv;
`ifdef MULTDIV_UNSIGNED_EN
      uns = op[0];
`else
      uns = 1'b0;
`endif
      sa = uns ? longint'({32'd0, a}) : longint'($signed(a));
      sb = uns ? longint'({32'd0, b}) : longint'($signed(b));
      dz = 1'b0;
      hi = 32'd0;
      lo = 32'd0;
      if (!op[1]) begin
         p  = sa * sb;
         hi = p[63:32];
         lo = p[31:0];
      end else if (b == 32'd0) begin
         dz = 1'b1;
      end else begin
         q  = sa / sb;
         r  = sa % sb;
         qv = q;
         rv = r;
         lo = qv[31:0];
         hi = rv[31:0];
      end
   endfunction

   int          mPhase = 0;
   int          mTotal = 35;
   bit          mSeenReset = 1'b0;
   logic        mDz = 1'b0;
   logic [31:0] mHi = 32'd0, mLo = 32'd0, mResHi = 32'd0, mResLo = 32'd0;

   // Model timeline: mPhase counts cycles since the accepted start, 0 means idle.
   always @(posedge Clk) begin
      if (Reset) begin
         mPhase     = 0;
         mHi        = 32'd0;
         mLo        = 32'd0;
         mSeenReset = 1'b1;
      end else if (mPhase == 0) begin
         if (HiWrite) mHi = WriteData;
         if (LoWrite) mLo = WriteData;
         if (Start) begin
            modelResult(Op, A, B, mResHi, mResLo, mDz);
            mTotal = mDz ? 2 : 35;
            mPhase = 1;
         end
      end else if (mPhase == mTotal) begin
         mPhase = 0;
      end else begin
         mPhase++;
         if (mPhase == mTotal && !mDz) begin
            mHi = mResHi;
            mLo = mResLo;
         end
      end
   end

   always @(negedge Clk) begin
      if (mSeenReset) begin
         checkOutput("busy", {31'd0, Busy}, {31'd0, (mPhase != 0)});
         checkOutput("done", {31'd0, Done}, {31'd0, (mPhase != 0 && mPhase == mTotal)});
         checkOutput("divzero", {31'd0, DivZero}, {31'd0, (mPhase != 0 && mPhase == mTotal && mDz)});
         checkOutput("hi", Hi, mHi);
         checkOutput("lo", Lo, mLo);
      end
   end

   task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic hiWr, input logic [31:0] wdata);
      @(negedge Clk);
      Start     = 1'b1;
      Op        = op;
      A         = a;
      B         = b;
      HiWrite   = hiWr;
      WriteData = wdata;
      @(negedge Clk);
      Start   = 1'b0;
      HiWrite = 1'b0;
   endtask

   task automatic waitDone(input string name, input int expCycles, input logic expDz, input bit interfere);
      int n = 1;
      while (Done !== 1'b1 && n < 60) begin
         if (interfere) begin
            if (n == 10) begin Start = 1'b1; A = 32'd5; B = 32'd5; end
            if (n == 11) Start = 1'b0;
            if (n == 20) begin HiWrite = 1'b1; WriteData = 32'hDEAD; end
            if (n == 21) HiWrite = 1'b0;
         end
         @(negedge Clk);
         n++;
      end
      checkOutput({name, "_latency"}, n, expCycles);
      checkOutput({name, "_divzero"}, {31'd0, DivZero}, {31'd0, expDz});
      @(negedge Clk);
      checkOutput({name, "_done_width"}, {31'd0, Done}, 32'd0);
      checkOutput({name, "_idle"}, {31'd0, Busy}, 32'd0);
   endtask

   initial begin
      int sawDone;
      repeat (3) @(negedge Clk);
      Reset = 1'b0;
      checkOutput("reset_hi", Hi, 32'd0);
      checkOutput("reset_lo", Lo, 32'd0);
      checkOutput("reset_busy", {31'd0, Busy}, 32'd0);

      applyStimulus(2'b00, 32'd7, 32'hFFFFFFFD, 1'b0, 32'd0);
      waitDone("mult_7_m3", 35, 1'b0, 1'b0);
      checkOutput("mult_7_m3_hi", Hi, 32'hFFFFFFFF);
      checkOutput("mult_7_m3_lo", Lo, 32'hFFFFFFEB);

      applyStimulus(2'b10, 32'hFFFFFFF9, 32'd2, 1'b0, 32'd0);
      waitDone("div_m7_2", 35, 1'b0, 1'b0);
      checkOutput("div_m7_2_hi", Hi, 32'hFFFFFFFF);
      checkOutput("div_m7_2_lo", Lo, 32'hFFFFFFFD);

      applyStimulus(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'd0);
      waitDone("div_min_m1", 35, 1'b0, 1'b0);
      checkOutput("div_min_m1_hi", Hi, 32'd0);
      checkOutput("div_min_m1_lo", Lo, 32'h80000000);

      applyStimulus(2'b01, 32'hFFFFFFFF, 32'd2, 1'b0, 32'd0);
      waitDone("multu", 35, 1'b0, 1'b0);
`ifdef MULTDIV_UNSIGNED_EN
      checkOutput("multu_hi", Hi, 32'd1);
`else
      checkOutput("multu_hi", Hi, 32'hFFFFFFFF);
`endif
      checkOutput("multu_lo", Lo, 32'hFFFFFFFE);

      applyStimulus(2'b11, 32'hFFFFFFFF, 32'd2, 1'b0, 32'd0);
      waitDone("divu", 35, 1'b0, 1'b0);
`ifdef MULTDIV_UNSIGNED_EN
      checkOutput("divu_hi", Hi, 32'd1);
      checkOutput("divu_lo", Lo, 32'h7FFFFFFF);
`else
      checkOutput("divu_hi", Hi, 32'hFFFFFFFF);
      checkOutput("divu_lo", Lo, 32'd0);
`endif

      @(negedge Clk);
      HiWrite   = 1'b1;
      WriteData = 32'h1234;
      @(negedge Clk);
      HiWrite = 1'b0;
      checkOutput("mthi", Hi, 32'h1234);
      applyStimulus(2'b10, 32'd99, 32'd0, 1'b0, 32'd0);
      waitDone("div_zero", 2, 1'b1, 1'b0);
      checkOutput("div_zero_hi", Hi, 32'h1234);
`ifdef MULTDIV_UNSIGNED_EN
      checkOutput("div_zero_lo", Lo, 32'h7FFFFFFF);
`else
      checkOutput("div_zero_lo", Lo, 32'd0);
`endif

      applyStimulus(2'b00, 32'd1000, 32'hFFFFFC18, 1'b0, 32'd0);
      waitDone("mult_busy_ignore", 35, 1'b0, 1'b1);
      checkOutput("mult_busy_ignore_hi", Hi, 32'hFFFFFFFF);
      checkOutput("mult_busy_ignore_lo", Lo, 32'hFFF0BDC0);

      applyStimulus(2'b00, 32'd7, 32'hFFFFFFFD, 1'b0, 32'd0);
      repeat (14) @(negedge Clk);
      Reset = 1'b1;
      @(negedge Clk);
      checkOutput("abort_busy", {31'd0, Busy}, 32'd0);
      checkOutput("abort_hi", Hi, 32'd0);
      checkOutput("abort_lo", Lo, 32'd0);
      Reset = 1'b0;
      sawDone = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge Clk);
         if (Done === 1'b1) sawDone++;
      end
      checkOutput("abort_no_done", sawDone, 32'd0);

      applyStimulus(2'b00, 32'd3, 32'd5, 1'b1, 32'hAAAA);
      checkOutput("start_with_mthi_hi", Hi, 32'hAAAA);
      waitDone("mult_3_5", 35, 1'b0, 1'b0);
      checkOutput("mult_3_5_hi", Hi, 32'd0);
      checkOutput("mult_3_5_lo", Lo, 32'd15);

      repeat (2) @(negedge Clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
